// File: rtl/frac_dec_pkg.sv
// Shared parameters, widths and FSM encoding for the L/M polyphase decimator scheduler.
// Changing L, M or TAPS_NUM here resizes every address and counter in the slice.
package frac_dec_pkg;

    localparam int L        = 2;
    localparam int M        = 3;
    localparam int TAPS_NUM = 138;
    localparam int MAC_LAT  = 2;

    localparam int P     = TAPS_NUM / L;
    localparam int AW    = $clog2(P);
    localparam int CW    = $clog2(TAPS_NUM);
    localparam int PW    = (L > 1) ? $clog2(L) : 1;
    localparam int ACC_W = $clog2(L + M);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_MAC   = 2'd2
    } state_t;

    // Circular delay-line pointer steps; compare-and-wrap avoids a modulo divider.
    function automatic logic [AW-1:0] dec_wrap(input logic [AW-1:0] a);
        return (a == '0) ? AW'(P - 1) : a - 1'b1;
    endfunction

    function automatic logic [AW-1:0] inc_wrap(input logic [AW-1:0] a);
        return (a == AW'(P - 1)) ? '0 : a + 1'b1;
    endfunction

endpackage

// File: rtl/frac_dec_scheduler_if.sv
// Sample handshake plus datapath control bus between the scheduler and the decimator datapath.
interface frac_dec_scheduler_if;
    import frac_dec_pkg::*;

    logic          EN;
    logic          bypass;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] samp_addr;
    logic [CW-1:0] coeff_addr;
    logic          mac_en;
    logic          mac_clr;
    logic          mac_last;
    logic [PW-1:0] phase;
    logic          byp_sel;
    logic          out_valid;

    modport master (
        input  EN, bypass, in_valid,
        output in_ready, wr_en, wr_addr, samp_addr, coeff_addr,
               mac_en, mac_clr, mac_last, phase, byp_sel, out_valid
    );

    modport slave (
        output EN, bypass, in_valid,
        input  in_ready, wr_en, wr_addr, samp_addr, coeff_addr,
               mac_en, mac_clr, mac_last, phase, byp_sel, out_valid
    );

endinterface

// File: rtl/frac_dec_addr_gen.sv
// Tap counter for one MAC job: walks coefficients of the selected phase (stride L)
// while walking the delay line backwards from the newest sample.
module frac_dec_addr_gen
    import frac_dec_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          step,
    input  logic [PW-1:0] phase_in,
    input  logic [AW-1:0] newest,
    output logic [CW-1:0] coeff_addr,
    output logic [AW-1:0] samp_addr,
    output logic          first,
    output logic          last
);

    logic [AW-1:0] k;

    always_ff @(posedge CLK) begin
        if (RST) begin
            k          <= '0;
            coeff_addr <= '0;
            samp_addr  <= '0;
        end else if (start) begin
            k          <= '0;
            coeff_addr <= CW'(phase_in);
            samp_addr  <= newest;
        end else if (step) begin
            k          <= k + 1'b1;
            coeff_addr <= coeff_addr + CW'(L);
            samp_addr  <= dec_wrap(samp_addr);
        end
    end

    assign first = (k == '0);
    assign last  = (k == AW'(P - 1));

endmodule

// File: rtl/frac_dec_scheduler.sv
// Control sequencer for the L/M polyphase fractional decimator sharing one MAC.
// Each accepted sample triggers zero or more P-tap jobs chosen by the phase accumulator.
module frac_dec_scheduler
    import frac_dec_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    frac_dec_scheduler_if.master bus
);

    state_t               state, nxt;
    logic [ACC_W-1:0]     acc;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        newest;
    logic [PW-1:0]        phase_q;
    logic [MAC_LAT-1:0]   vld_pipe;
    logic                 byp_q;
    logic                 accept, job_start, in_mac;
    logic                 tap_first, tap_last;
    logic                 mac_en, mac_clr, mac_last;

    assign bus.in_ready = (state == S_IDLE) & bus.EN & ~RST;
    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.wr_en    = accept & ~bus.bypass;
    assign bus.wr_addr  = wr_ptr;
    assign newest       = dec_wrap(wr_ptr);
    assign job_start    = (state == S_CHECK) && (acc < ACC_W'(L));
    assign in_mac       = (state == S_MAC);

    frac_dec_addr_gen u_addr (
        .CLK        (CLK),
        .RST        (RST),
        .start      (job_start),
        .step       (in_mac),
        .phase_in   (PW'(acc)),
        .newest     (newest),
        .coeff_addr (bus.coeff_addr),
        .samp_addr  (bus.samp_addr),
        .first      (tap_first),
        .last       (tap_last)
    );

    always_comb begin
        nxt      = state;
        mac_en   = 1'b0;
        mac_clr  = 1'b0;
        mac_last = 1'b0;
        case (state)
            S_IDLE:  if (accept && !bus.bypass) nxt = S_CHECK;
            S_CHECK: nxt = job_start ? S_MAC : S_IDLE;
            S_MAC: begin
                mac_en   = 1'b1;
                mac_clr  = tap_first;
                mac_last = tap_last;
                if (tap_last) nxt = S_CHECK;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            acc      <= '0;
            wr_ptr   <= '0;
            phase_q  <= '0;
            vld_pipe <= '0;
            byp_q    <= 1'b0;
        end else begin
            state <= nxt;
            if (bus.wr_en) wr_ptr <= inc_wrap(wr_ptr);
            // CHECK either launches a job for this phase or retires L from the accumulator.
            if (state == S_CHECK) begin
                if (job_start) begin
                    phase_q <= PW'(acc);
                    acc     <= acc + ACC_W'(M);
                end else begin
                    acc <= acc - ACC_W'(L);
                end
            end
            byp_q    <= accept & bus.bypass;
            vld_pipe <= (vld_pipe << 1) | MAC_LAT'(mac_last);
        end
    end

    assign bus.mac_en    = mac_en;
    assign bus.mac_clr   = mac_clr;
    assign bus.mac_last  = mac_last;
    assign bus.phase     = phase_q;
    assign bus.byp_sel   = byp_q;
    assign bus.out_valid = vld_pipe[MAC_LAT-1] | byp_q;

endmodule

// File: tb/tb_frac_dec_scheduler.sv
// Directed bench for frac_dec_scheduler: per-sample vector table plus hand-written
// sequences for bypass, enable drop, mid-job reset and a long random-gap run.
module tb_frac_dec_scheduler;
    import frac_dec_pkg::*;

    logic CLK_tb;
    logic RST;
    frac_dec_scheduler_if bus ();

    frac_dec_scheduler dut (
        .CLK (CLK_tb),
        .RST (RST),
        .bus (bus)
    );

    initial CLK_tb = 1'b0;
    always #5 CLK_tb = ~CLK_tb;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor statistics; only the monitor writes these.
    int cyc = 0, ov_cnt = 0, ml_cnt = 0, men_cnt = 0, byp_cnt = 0, acc_cnt = 0;
    int lat_err = 0, busy_acc = 0, last_job = -10;
    logic m1 = 1'b0, m2 = 1'b0, b1 = 1'b0;

    always @(negedge CLK_tb) begin
        logic acc_now, exp_ov;
        #2;
        cyc++;
        exp_ov = m2 | b1;
        if (bus.out_valid !== exp_ov) lat_err++;
        if (bus.byp_sel !== b1) lat_err++;
        if (bus.out_valid) ov_cnt++;
        if (bus.mac_last) ml_cnt++;
        if (bus.mac_en) men_cnt++;
        if (bus.byp_sel) byp_cnt++;
        acc_now = bus.in_valid & bus.in_ready;
        if (acc_now) acc_cnt++;
        if (acc_now && bus.mac_en) busy_acc++;
        if (acc_now && (cyc - last_job) < 2) busy_acc++;
        if (acc_now && !bus.bypass) last_job = cyc;
        m2 = m1 & ~RST;
        m1 = bus.mac_last & ~RST;
        b1 = acc_now & bus.bypass & ~RST;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Offers one sample, then follows the scheduler until it is ready again,
    // checking every MAC tap's addresses and flags against the expected phase/newest.
    task automatic run_sample(input logic byp, input int newest, input int ph,
                              output int rdy, output int wen, output int wad,
                              output int busy, output int nmac, output int err);
        int es;
        @(negedge CLK_tb);
        bus.in_valid = 1'b1;
        bus.bypass   = byp;
        #1;
        rdy = int'(bus.in_ready);
        wen = int'(bus.wr_en);
        wad = int'(bus.wr_addr);
        busy = 0; nmac = 0; err = 0;
        @(negedge CLK_tb);
        bus.in_valid = 1'b0;
        bus.bypass   = 1'b0;
        #1;
        for (int c = 0; c < P + 20 && !bus.in_ready; c++) begin
            busy++;
            if (bus.mac_en) begin
                es = ((newest - nmac) % P + P) % P;
                if (int'(bus.coeff_addr) != nmac * L + ph) err++;
                if (int'(bus.samp_addr) != es) err++;
                if (int'(bus.phase) != ph) err++;
                if (bus.mac_clr != (nmac == 0)) err++;
                if (bus.mac_last != (nmac == P - 1)) err++;
                nmac++;
            end
            @(negedge CLK_tb);
            #1;
        end
        repeat (3) @(negedge CLK_tb);
    endtask

    typedef struct {
        logic byp;
        int   kind;   // 0 no job, 1 MAC job, 2 bypass
        int   ph;
        int   waddr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int rdy, wen, wad, busy, nmac, err;
        int ov0, byp0, men0, acc0, ml0, n, found, hi, wr0, acc_n;
        int e_busy, e_nmac, e_ov;

        tbl[0] = '{1'b0, 1, 0, 0};
        tbl[1] = '{1'b0, 1, 1, 1};
        tbl[2] = '{1'b0, 0, 0, 2};
        tbl[3] = '{1'b1, 2, 0, 3};
        tbl[4] = '{1'b0, 1, 0, 3};
        tbl[5] = '{1'b0, 1, 1, 4};
        tbl[6] = '{1'b0, 0, 0, 5};

        RST = 1'b1;
        bus.EN = 1'b1;
        bus.bypass = 1'b0;
        bus.in_valid = 1'b1;

        // Reset holds every output low even with in_valid asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK_tb);
            #1;
            chk("reset_outputs", int'({bus.in_ready, bus.wr_en, bus.mac_en, bus.mac_clr,
                                       bus.mac_last, bus.out_valid, bus.byp_sel}), 0);
        end
        @(negedge CLK_tb);
        RST = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("reset_acc", int'(dut.acc), 0);
        chk("reset_wr_ptr", int'(bus.wr_addr), 0);
        chk("ready_after_reset", int'(bus.in_ready), 1);

        // Table: ratio 2 jobs per 3 samples, phases 0/1, addressing with wrap, bypass.
        for (int i = 0; i < 7; i++) begin
            ov0 = ov_cnt; byp0 = byp_cnt;
            run_sample(tbl[i].byp, tbl[i].waddr, tbl[i].ph, rdy, wen, wad, busy, nmac, err);
            e_busy = (tbl[i].kind == 1) ? P + 2 : (tbl[i].kind == 0) ? 1 : 0;
            e_nmac = (tbl[i].kind == 1) ? P : 0;
            e_ov   = (tbl[i].kind == 0) ? 0 : 1;
            chk($sformatf("v%0d_ready", i), rdy, 1);
            chk($sformatf("v%0d_wr_en", i), wen, tbl[i].byp ? 0 : 1);
            chk($sformatf("v%0d_wr_addr", i), wad, tbl[i].waddr);
            chk($sformatf("v%0d_busy_cycles", i), busy, e_busy);
            chk($sformatf("v%0d_mac_taps", i), nmac, e_nmac);
            chk($sformatf("v%0d_tap_errors", i), err, 0);
            chk($sformatf("v%0d_out_valid", i), ov_cnt - ov0, e_ov);
            chk($sformatf("v%0d_byp_sel", i), byp_cnt - byp0, (tbl[i].kind == 2) ? 1 : 0);
        end

        // Bypass burst: five back-to-back pass-through samples, no MAC, no writes.
        wr0 = int'(bus.wr_addr);
        ov0 = ov_cnt; byp0 = byp_cnt; men0 = men_cnt;
        n = 0; hi = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK_tb);
            bus.in_valid = 1'b1;
            bus.bypass   = 1'b1;
            #1;
            if (bus.in_valid && bus.in_ready) n++;
            if (bus.wr_en) hi++;
        end
        @(negedge CLK_tb);
        bus.in_valid = 1'b0;
        bus.bypass   = 1'b0;
        repeat (3) @(negedge CLK_tb);
        #1;
        chk("byp_accepts", n, 5);
        chk("byp_out_valid", ov_cnt - ov0, 5);
        chk("byp_sel_pulses", byp_cnt - byp0, 5);
        chk("byp_no_mac", men_cnt - men0, 0);
        chk("byp_no_wr_en", hi, 0);
        chk("byp_wr_ptr_kept", int'(bus.wr_addr), wr0);

        // EN dropped right after an accept: the job completes, nothing else accepted.
        ov0 = ov_cnt; men0 = men_cnt; acc0 = acc_cnt; hi = 0;
        @(negedge CLK_tb);
        bus.in_valid = 1'b1;
        #1;
        @(negedge CLK_tb);
        bus.EN = 1'b0;
        for (int c = 0; c < P + 10; c++) begin
            @(negedge CLK_tb);
            #1;
            if (bus.in_ready) hi++;
        end
        chk("en_ready_low", hi, 0);
        chk("en_job_taps", men_cnt - men0, P);
        chk("en_job_out_valid", ov_cnt - ov0, 1);
        chk("en_accepts", acc_cnt - acc0, 1);
        chk("en_acc_kept", int'(dut.acc), 1);
        chk("en_wr_ptr_kept", int'(bus.wr_addr), 7);
        @(negedge CLK_tb);
        bus.in_valid = 1'b0;
        bus.EN = 1'b1;

        // Reset at tap k=30 aborts the job and its pending out_valid.
        @(negedge CLK_tb); RST = 1'b1;
        @(negedge CLK_tb); RST = 1'b0;
        @(negedge CLK_tb);
        bus.in_valid = 1'b1;
        #1;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK_tb);
            bus.in_valid = 1'b0;
            #1;
            if (bus.mac_en && int'(bus.coeff_addr) == 30 * L) begin
                found = 1;
                break;
            end
        end
        chk("rst_mid_reached_k30", found, 1);
        RST = 1'b1;
        ov0 = ov_cnt;
        @(negedge CLK_tb);
        RST = 1'b0;
        #1;
        chk("rst_mid_mac_dropped", int'(bus.mac_en), 0);
        repeat (10) @(negedge CLK_tb);
        chk("rst_mid_no_out_valid", ov_cnt - ov0, 0);
        run_sample(1'b0, 0, 0, rdy, wen, wad, busy, nmac, err);
        chk("rst_mid_next_wr_addr", wad, 0);
        chk("rst_mid_next_taps", nmac, P);
        chk("rst_mid_next_phase0", err, 0);

        // Long run with random in_valid gaps: exactly L outputs per M inputs.
        @(negedge CLK_tb); RST = 1'b1;
        @(negedge CLK_tb); RST = 1'b0;
        ov0 = ov_cnt; ml0 = ml_cnt;
        acc_n = 0;
        for (int c = 0; c < 60000 && acc_n < 600; c++) begin
            @(negedge CLK_tb);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.in_valid && bus.in_ready) acc_n++;
        end
        @(negedge CLK_tb);
        bus.in_valid = 1'b0;
        repeat (80) @(negedge CLK_tb);
        #3;
        chk("long_accepts", acc_n, 600);
        chk("long_out_valid", ov_cnt - ov0, 400);
        chk("long_mac_last", ml_cnt - ml0, 400);
        chk("out_valid_latency_errors", lat_err, 0);
        chk("accept_while_busy", busy_acc, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
